bitmanip_sequencer: RTL and testbench

Sequences the execute-stage bit-manipulation unit (BMU) and owns all multi-cycle bit-manipulation work. Accepts one operation at a time from the execute issue logic over a valid/ready handshake. Single-cycle-class ops are driven onto the BMU with stable operands. Carry-less multiply ops are iterated in an internal engine. The block holds the result until writeback accepts it, and stalls the pipeline while busy.

---
 rtl/bitmanip_pkg.sv | 36 +++
 rtl/clmul_iter.sv | 90 +++++++++
 rtl/bitmanip_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_bitmanip_sequencer.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/bitmanip_pkg.sv
// bitmanip_pkg
//   Shared definitions for the execute-stage bit-manipulation path:
//   carry-less multiply / illegal op codes, the sequencer state encoding
//   and the op-class decode used to route an accepted op.
package bitmanip_pkg;

    localparam int XLEN = 32;

    localparam logic [4:0] BITOP_CLMUL   = 5'd28;
    localparam logic [4:0] BITOP_CLMULH  = 5'd29;
    localparam logic [4:0] BITOP_CLMULR  = 5'd30;
    localparam logic [4:0] BITOP_ILLEGAL = 5'd31;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_ITER  = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_e;

    typedef enum logic [1:0] {
        OPC_SINGLE  = 2'd0,
        OPC_CLMUL   = 2'd1,
        OPC_ILLEGAL = 2'd2
    } op_class_e;

    function automatic op_class_e decode_op_class(input logic [4:0] op);
        if (op == BITOP_ILLEGAL) begin
            return OPC_ILLEGAL;
        end else if (op == BITOP_CLMUL || op == BITOP_CLMULH || op == BITOP_CLMULR) begin
            return OPC_CLMUL;
        end
        return OPC_SINGLE;
    endfunction

endpackage

// File: rtl/clmul_iter.sv
// clmul_iter
//   Iterative carry-less multiplier. Consumes BITS_PER_CYCLE multiplier bits
//   per step, LSB first, folding shifted copies of rs1 into a 64-bit
//   accumulator.
//   Ports:
//     clk_i, rst_i     clock, async active-high reset
//     start_i          load operands, clear accumulator and step count
//     step_i           perform one iteration
//     clear_i          flush: zero all state (wins over start/step)
//     op_i             CLMUL / CLMULH / CLMULR result select
//     rs1_i, rs2_i     operands sampled on start_i
//     last_o           current step is the final one
//     result_o         selected result including the current step
module clmul_iter
    import bitmanip_pkg::*;
#(
    parameter int BITS_PER_CYCLE = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        step_i,
    input  logic        clear_i,
    input  logic [4:0]  op_i,
    input  logic [31:0] rs1_i,
    input  logic [31:0] rs2_i,
    output logic        last_o,
    output logic [31:0] result_o
);

    localparam int ITERS = XLEN / BITS_PER_CYCLE;

    logic [63:0] acc_q, acc_d;
    logic [63:0] mcand_q, mcand_d;   // rs1 pre-shifted to the current bit position
    logic [31:0] mplier_q, mplier_d; // remaining rs2 bits, next ones at LSB
    logic [5:0]  cnt_q, cnt_d;

    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        if (clear_i) begin
            acc_d    = '0;
            mcand_d  = '0;
            mplier_d = '0;
            cnt_d    = '0;
        end else if (start_i) begin
            acc_d    = '0;
            mcand_d  = {32'b0, rs1_i};
            mplier_d = rs2_i;
            cnt_d    = '0;
        end else if (step_i) begin
            for (int j = 0; j < BITS_PER_CYCLE; j++) begin
                if (mplier_q[j]) begin
                    acc_d = acc_d ^ (mcand_q << j);
                end
            end
            mcand_d  = mcand_q << BITS_PER_CYCLE;
            mplier_d = mplier_q >> BITS_PER_CYCLE;
            cnt_d    = cnt_q + 6'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end

    assign last_o = step_i && !clear_i && (cnt_q == 6'(ITERS - 1));

    // Selected from acc_d so the owner can register the result on the last step.
    always_comb begin
        case (op_i)
            BITOP_CLMULH: result_o = acc_d[63:32];
            BITOP_CLMULR: result_o = acc_d[62:31];
            default:      result_o = acc_d[31:0];
        endcase
    end

endmodule

// File: rtl/bitmanip_sequencer.sv
// bitmanip_sequencer
//   Accepts one bit-manipulation op at a time, drives single-cycle-class ops
//   onto the BMU with stable operands, iterates carry-less multiplies in
//   clmul_iter, and holds the result until writeback takes it.
//   Ports:
//     clk_i, rst_i                      clock, async active-high reset
//     req_valid_i/req_ready_o           request handshake
//     req_op_i, req_rs1_i, req_rs2_i,
//     req_rd_i                          request payload
//     flush_i                           kill in-flight op, return to IDLE
//     bmu_op_o, bmu_operand1_o/2_o      BMU drive (zero outside ISSUE)
//     bmu_result_i                      BMU result
//     res_valid_o/res_ready_i           result handshake
//     res_data_o, res_rd_o              registered result and tag
//     busy_o                            pipeline stall
module bitmanip_sequencer
    import bitmanip_pkg::*;
#(
    parameter int BMU_LATENCY          = 1,
    parameter int CLMUL_BITS_PER_CYCLE = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [4:0]  req_op_i,
    input  logic [31:0] req_rs1_i,
    input  logic [31:0] req_rs2_i,
    input  logic [4:0]  req_rd_i,
    input  logic        flush_i,
    output logic [4:0]  bmu_op_o,
    output logic [31:0] bmu_operand1_o,
    output logic [31:0] bmu_operand2_o,
    input  logic [31:0] bmu_result_i,
    output logic        res_valid_o,
    input  logic        res_ready_i,
    output logic [31:0] res_data_o,
    output logic [4:0]  res_rd_o,
    output logic        busy_o
);

    seq_state_e  state_q, state_d;
    logic [4:0]  op_q, op_d;
    logic [31:0] rs1_q, rs1_d;
    logic [31:0] rs2_q, rs2_d;
    logic [4:0]  rd_q, rd_d;
    logic [2:0]  lat_cnt_q, lat_cnt_d;
    logic [31:0] res_data_q, res_data_d;
    logic [4:0]  res_rd_q, res_rd_d;

    logic        accept;
    op_class_e   req_class;
    logic        lat_last;
    logic        clmul_last;
    logic [31:0] clmul_result;

    assign accept    = req_valid_i && req_ready_o;
    assign req_class = decode_op_class(req_op_i);
    assign lat_last  = (lat_cnt_q == 3'(BMU_LATENCY - 1));

    clmul_iter #(
        .BITS_PER_CYCLE(CLMUL_BITS_PER_CYCLE)
    ) u_clmul_iter (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .start_i (accept && req_class == OPC_CLMUL),
        .step_i  (state_q == ST_ITER && !flush_i),
        .clear_i (flush_i),
        .op_i    (op_q),
        .rs1_i   (req_rs1_i),
        .rs2_i   (req_rs2_i),
        .last_o  (clmul_last),
        .result_o(clmul_result)
    );

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    case (req_class)
                        OPC_CLMUL:   state_d = ST_ITER;
                        OPC_ILLEGAL: state_d = ST_DONE;
                        default:     state_d = ST_ISSUE;
                    endcase
                end
            end
            ST_ISSUE: if (lat_last)    state_d = ST_DONE;
            ST_ITER:  if (clmul_last)  state_d = ST_DONE;
            ST_DONE:  if (res_ready_i) state_d = ST_IDLE;
            default:                   state_d = ST_IDLE;
        endcase
        if (flush_i) begin
            state_d = ST_IDLE;
        end
    end

    // Outputs
    always_comb begin
        req_ready_o    = (state_q == ST_IDLE) && !flush_i && !rst_i;
        busy_o         = (state_q != ST_IDLE);
        res_valid_o    = (state_q == ST_DONE);
        bmu_op_o       = '0;
        bmu_operand1_o = '0;
        bmu_operand2_o = '0;
        if (state_q == ST_ISSUE) begin
            bmu_op_o       = op_q;
            bmu_operand1_o = rs1_q;
            bmu_operand2_o = rs2_q;
        end
    end

    // Request latch, BMU latency count and result register
    always_comb begin
        op_d       = op_q;
        rs1_d      = rs1_q;
        rs2_d      = rs2_q;
        rd_d       = rd_q;
        lat_cnt_d  = '0;
        res_data_d = res_data_q;
        res_rd_d   = res_rd_q;
        if (accept) begin
            op_d  = req_op_i;
            rs1_d = req_rs1_i;
            rs2_d = req_rs2_i;
            rd_d  = req_rd_i;
        end
        if (state_q == ST_ISSUE && !lat_last && !flush_i) begin
            lat_cnt_d = lat_cnt_q + 3'd1;
        end
        // Result/tag are zero outside DONE so a discarded op leaves nothing behind.
        if (flush_i) begin
            res_data_d = '0;
            res_rd_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept && req_class == OPC_ILLEGAL) begin
                        res_data_d = '0;
                        res_rd_d   = req_rd_i;
                    end
                end
                ST_ISSUE: begin
                    if (lat_last) begin
                        res_data_d = bmu_result_i;
                        res_rd_d   = rd_q;
                    end
                end
                ST_ITER: begin
                    if (clmul_last) begin
                        res_data_d = clmul_result;
                        res_rd_d   = rd_q;
                    end
                end
                ST_DONE: begin
                    if (res_ready_i) begin
                        res_data_d = '0;
                        res_rd_d   = '0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            op_q       <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
            lat_cnt_q  <= '0;
            res_data_q <= '0;
            res_rd_q   <= '0;
        end else begin
            op_q       <= op_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            rd_q       <= rd_d;
            lat_cnt_q  <= lat_cnt_d;
            res_data_q <= res_data_d;
            res_rd_q   <= res_rd_d;
        end
    end

    assign res_data_o = res_data_q;
    assign res_rd_o   = res_rd_q;

endmodule

// File: tb/tb_bitmanip_sequencer.sv
module tb_bitmanip_sequencer;

    localparam int LAT = 1;
    localparam int CPB = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [4:0]  req_op;
    logic [31:0] req_rs1;
    logic [31:0] req_rs2;
    logic [4:0]  req_rd;
    logic        flush;
    logic [4:0]  bmu_op;
    logic [31:0] bmu_a;
    logic [31:0] bmu_b;
    logic [31:0] bmu_res;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic [4:0]  res_rd;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bitmanip_sequencer #(
        .BMU_LATENCY(LAT),
        .CLMUL_BITS_PER_CYCLE(CPB)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_op_i(req_op), .req_rs1_i(req_rs1), .req_rs2_i(req_rs2), .req_rd_i(req_rd),
        .flush_i(flush),
        .bmu_op_o(bmu_op), .bmu_operand1_o(bmu_a), .bmu_operand2_o(bmu_b),
        .bmu_result_i(bmu_res),
        .res_valid_o(res_valid), .res_ready_i(res_ready),
        .res_data_o(res_data), .res_rd_o(res_rd),
        .busy_o(busy)
    );

    // Stand-in BMU: any deterministic function of op and operands will do.
    function automatic logic [31:0] bmu_fn(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        return (a ^ {b[15:0], b[31:16]}) + {27'b0, op};
    endfunction

    assign bmu_res = bmu_fn(bmu_op, bmu_a, bmu_b);

    // Full 32x32 carry-less product, one bit at a time, then the op's window.
    function automatic logic [31:0] clmul_ref(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        p = '0;
        for (int i = 0; i < 32; i++)
            if (b[i]) p = p ^ ({32'b0, a} << i);
        if (op == 5'd29) return p[63:32];
        if (op == 5'd30) return p[62:31];
        return p[31:0];
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input int hold);
        logic [31:0] expd;
        int          exp_lat;
        int          n;
        logic        il, cl;
        il      = (op == 5'd31);
        cl      = (op >= 5'd28) && !il;
        expd    = il ? 32'd0 : (cl ? clmul_ref(op, a, b) : bmu_fn(op, a, b));
        exp_lat = il ? 0 : (cl ? 32 / CPB : LAT);
        check("ready_idle", req_ready, 1);
        req_valid = 1'b1; req_op = op; req_rs1 = a; req_rs2 = b; req_rd = rd;
        tick();
        req_valid = 1'b0;
        n = 0;
        while (!res_valid && n < 100) begin
            check("busy_wait", busy, 1);
            if (cl || il) begin
                check("bmu_quiet", {bmu_op, bmu_a, bmu_b}, 0);
            end else begin
                check("bmu_op", bmu_op, op);
                check("bmu_ops", {bmu_a, bmu_b}, {a, b});
            end
            tick();
            n++;
        end
        check("latency", n, exp_lat);
        check("res_data", res_data, expd);
        check("res_rd", res_rd, rd);
        repeat (hold) begin
            tick();
            check("bp_valid", res_valid, 1);
            check("bp_data", res_data, expd);
            check("bp_rd", res_rd, rd);
            check("bp_ready", req_ready, 0);
            check("bp_busy", busy, 1);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check("post_valid", res_valid, 0);
        check("post_busy", busy, 0);
        check("post_ready", req_ready, 1);
    endtask

    initial begin
        logic [4:0]  op;
        logic [31:0] a, b;
        rst = 1'b1; req_valid = 1'b0; req_op = '0; req_rs1 = '0; req_rs2 = '0;
        req_rd = '0; flush = 1'b0; res_ready = 1'b0;

        // Reset state
        #1;
        check("rst_ready", req_ready, 0);
        check("rst_outs", {res_valid, busy, res_data, res_rd, bmu_op, bmu_a, bmu_b}, 0);
        tick(); tick();
        rst = 1'b0;
        #1;
        check("rel_ready", req_ready, 1);
        tick();

        // Directed
        do_op(5'd5, 32'h0000_00F0, 32'h1234_5678, 5'd3, 0);
        do_op(5'd28, 32'h3, 32'h3, 5'd7, 0);
        check("clmul_3x3", clmul_ref(5'd28, 32'h3, 32'h3), 32'h5);
        do_op(5'd29, 32'h8000_0000, 32'h8000_0000, 5'd9, 0);
        do_op(5'd30, 32'h8000_0000, 32'h8000_0000, 5'd10, 0);
        do_op(5'd12, 32'hDEAD_BEEF, 32'h0BAD_F00D, 5'd17, 5);
        do_op(5'd31, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd31, 2);

        // Flush in the 4th ITER cycle with a competing CLMUL request
        req_valid = 1'b1; req_op = 5'd28; req_rs1 = 32'hFFFF_FFFF; req_rs2 = 32'hFFFF_FFFF; req_rd = 5'd4;
        tick();
        req_valid = 1'b0;
        tick(); tick(); tick();
        check("fl_busy_pre", busy, 1);
        flush = 1'b1; req_valid = 1'b1; req_op = 5'd28; req_rs1 = 32'h1; req_rs2 = 32'h1;
        #1;
        check("fl_ready", req_ready, 0);
        tick();
        flush = 1'b0; req_valid = 1'b0;
        check("fl_busy", busy, 0);
        check("fl_valid", res_valid, 0);
        repeat (10) begin
            tick();
            check("fl_quiet", {res_valid, busy}, 0);
        end
        do_op(5'd28, 32'h0000_0013, 32'h0000_0101, 5'd6, 0);

        // Reset during ISSUE
        req_valid = 1'b1; req_op = 5'd5; req_rs1 = 32'hA5A5_A5A5; req_rs2 = 32'h5A5A_5A5A; req_rd = 5'd21;
        tick();
        req_valid = 1'b0;
        check("iss_busy", busy, 1);
        rst = 1'b1;
        #1;
        check("mid_rst_outs", {res_valid, busy, req_ready, res_data, res_rd, bmu_op, bmu_a, bmu_b}, 0);
        tick();
        rst = 1'b0;
        #1;
        check("mid_rst_rel", {req_ready, res_valid}, 2'b10);
        tick();
        do_op(5'd31, 32'h1234_5678, 32'h9ABC_DEF0, 5'd13, 0);

        // Randomized ops against the reference model
        for (int k = 0; k < 24; k++) begin
            op = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 2) == 0) op = 5'(28 + $urandom_range(0, 2));
            a = $urandom;
            b = $urandom;
            do_op(op, a, b, 5'($urandom_range(0, 31)), int'($urandom_range(0, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
